// File: rtl/seq_add_pkg.sv
// seq_add_pkg: shared byte width and controller state encoding for the byte-serial adder.
package seq_add_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/rca_8bit.sv
// rca_8bit: 8-bit ripple-carry adder slice.
module rca_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic       Cout,
  output logic [7:0] Sum
);
  logic [8:0] c;
  assign c[0] = Cin;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign Sum[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign Cout = c[8];
endmodule

// File: rtl/seq_add64_ctrl.sv
// seq_add64_ctrl: byte-serial adder, one shared 8-bit slice per clock, LSB byte first, valid/ready handshake.
module seq_add64_ctrl
  import seq_add_pkg::*;
#(
  parameter  int NBYTES = 8,
  localparam int W      = BYTE_W * NBYTES,
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic [BYTE_W-1:0] byte_sum;
  logic byte_co, last;
  rca_8bit u_rca (
    .A   (a_q[cnt_q*BYTE_W +: BYTE_W]),
    .B   (b_q[cnt_q*BYTE_W +: BYTE_W]),
    .Cin (carry_q),
    .Cout(byte_co),
    .Sum (byte_sum)
  );
  assign last = cnt_q == CW'(NBYTES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[cnt_q*BYTE_W +: BYTE_W] = byte_sum;
        carry_d = byte_co;
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        cout_d  = last ? byte_co : cout_q;
        state_d = last ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule
